// File: rtl/accum_stream_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : accum_stream_driver
//  Purpose  : Transmit-side framer for the complex accumulator. Takes a
//             length-configured burst of complex samples from a valid/ready
//             source, drives a contiguous zero-padded stream with start/stop
//             framing into the accumulator, then waits for the accumulator's
//             output_valid and returns the captured sum as a one-cycle result.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Complex samples are packed as {re[DATA_W-1:0], im[DATA_W-1:0]}.
//
//  Ports:
//    clk                  clock
//    reset                synchronous, active-high reset
//    i_config_valid       load new burst length (honoured in IDLE only)
//    i_config_length      burst length N
//    o_busy               high whenever the framer is not IDLE
//    i_in_data            upstream sample
//    i_in_valid           upstream sample valid
//    o_in_ready           sample accepted this cycle when i_in_valid is high
//    o_acc_in             accumulator data input (zero when no sample taken)
//    o_acc_start          accumulator start pulse (first RUN cycle)
//    o_acc_stop           accumulator stop pulse (last FLUSH cycle)
//    i_acc_out            accumulator sum
//    i_acc_output_valid   accumulator sum valid
//    o_result             captured sum, held until the next capture
//    o_result_valid       one-cycle pulse marking a new o_result
//    o_stall_count        (ACC_DRV_STATS_EN only) RUN cycles with the driver
//                         ready but no upstream sample
//
//  Optional build macro: ACC_DRV_STATS_EN adds the stall counter output.
// ============================================================================
module accum_stream_driver #(
    parameter int MAX_LEN_BITS = 9,
    parameter int MIN_LEN      = 12,
    parameter int STOP_DELAY   = 11,
    parameter int DATA_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_config_valid,
    input  logic [MAX_LEN_BITS-1:0] i_config_length,
    output logic                    o_busy,
    input  logic [2*DATA_W-1:0]     i_in_data,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    output logic [2*DATA_W-1:0]     o_acc_in,
    output logic                    o_acc_start,
    output logic                    o_acc_stop,
    input  logic [2*DATA_W-1:0]     i_acc_out,
    input  logic                    i_acc_output_valid,
    output logic [2*DATA_W-1:0]     o_result,
    output logic                    o_result_valid
`ifdef ACC_DRV_STATS_EN
    ,
    output logic [MAX_LEN_BITS+3:0] o_stall_count
`endif
);

    // Counters carry one spare bit so a full-length burst never wraps.
    localparam int CW = MAX_LEN_BITS + 1;
    localparam int FW = (STOP_DELAY > 1) ? $clog2(STOP_DELAY) : 1;

    localparam logic [CW-1:0] c_MIN_M1     = CW'(MIN_LEN - 1);
    localparam logic [FW-1:0] c_FLUSH_LAST = FW'(STOP_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Sub-phases of WAIT: waiting for the sum, sum captured, result pulse.
    localparam logic [1:0] c_WPH_WAIT = 2'd0;
    localparam logic [1:0] c_WPH_CAPT = 2'd1;
    localparam logic [1:0] c_WPH_PULS = 2'd2;

    state_t              r_state;
    logic [CW-1:0]       r_len;
    logic [CW-1:0]       r_acc;      // samples accepted so far
    logic [CW-1:0]       r_cyc;      // RUN cycles completed, saturates at MIN_LEN-1
    logic [FW-1:0]       r_fl;       // FLUSH cycle index
    logic [1:0]          r_wph;
    logic [2*DATA_W-1:0] r_cap;
    logic [2*DATA_W-1:0] r_result;
    logic                r_result_valid;
    logic                r_start;
    logic                r_stop;

    logic                w_in_ready;
    logic                w_fire;
    logic [CW-1:0]       w_acc_nx;
    logic                w_run_done;

    assign w_in_ready = (r_state == ST_RUN) && (r_acc < r_len);
    assign w_fire     = w_in_ready && i_in_valid;
    assign w_acc_nx   = r_acc + {{(CW-1){1'b0}}, w_fire};
    // RUN ends once all N samples are in and at least MIN_LEN cycles
    // (counting the current one) have been presented to the accumulator.
    assign w_run_done = (w_acc_nx == r_len) && (r_cyc >= c_MIN_M1);

    // Stalls and padding cycles drive zeros so the accumulator always sees a
    // contiguous stream whose sum equals the sum of the accepted samples.
    assign o_acc_in       = w_fire ? i_in_data : '0;
    assign o_in_ready     = w_in_ready;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_acc_start    = r_start;
    assign o_acc_stop     = r_stop;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;

`ifdef ACC_DRV_STATS_EN
    logic [MAX_LEN_BITS+3:0] r_stall;
    assign o_stall_count = r_stall;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_len          <= '0;
            r_acc          <= '0;
            r_cyc          <= '0;
            r_fl           <= '0;
            r_wph          <= c_WPH_WAIT;
            r_cap          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_start        <= 1'b0;
            r_stop         <= 1'b0;
`ifdef ACC_DRV_STATS_EN
            r_stall        <= '0;
`endif
        end else begin
            r_start        <= 1'b0;
            r_stop         <= 1'b0;
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_config_valid) begin
                        r_len   <= {1'b0, i_config_length};
                        r_acc   <= '0;
                        r_cyc   <= '0;
                        r_start <= 1'b1;
                        r_state <= ST_RUN;
`ifdef ACC_DRV_STATS_EN
                        r_stall <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nx;
                    if (r_cyc < c_MIN_M1) begin
                        r_cyc <= r_cyc + 1'b1;
                    end
`ifdef ACC_DRV_STATS_EN
                    if (w_in_ready && !i_in_valid && (r_stall != '1)) begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                    if (w_run_done) begin
                        r_fl    <= '0;
                        r_stop  <= (STOP_DELAY == 1);
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (r_fl == c_FLUSH_LAST) begin
                        r_wph   <= c_WPH_WAIT;
                        r_state <= ST_WAIT;
                    end else begin
                        r_fl   <= r_fl + 1'b1;
                        // Stop is registered, so it is armed one cycle early.
                        r_stop <= ((r_fl + 1'b1) == c_FLUSH_LAST);
                    end
                end
                ST_WAIT: begin
                    case (r_wph)
                        c_WPH_WAIT: begin
                            if (i_acc_output_valid) begin
                                r_cap <= i_acc_out;
                                r_wph <= c_WPH_CAPT;
                            end
                        end
                        c_WPH_CAPT: begin
                            r_result       <= r_cap;
                            r_result_valid <= 1'b1;
                            r_wph          <= c_WPH_PULS;
                        end
                        default: begin
                            // Result pulse is on the outputs this cycle;
                            // a config request now is deliberately not seen.
                            r_wph   <= c_WPH_WAIT;
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accum_stream_driver.sv
`timescale 1ns/1ps
`default_nettype none
module tb_accum_stream_driver;

    localparam int MLB        = 9;
    localparam int MIN_LEN    = 12;
    localparam int STOP_DELAY = 11;
    localparam int DW         = 16;
    localparam int ACC_LAT    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_v;
    logic [MLB-1:0] cfg_len;
    logic          busy;
    logic [2*DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [2*DW-1:0] acc_in;
    logic          acc_start;
    logic          acc_stop;
    logic [2*DW-1:0] acc_out;
    logic          acc_ov;
    logic [2*DW-1:0] result;
    logic          result_valid;
`ifdef ACC_DRV_STATS_EN
    logic [MLB+3:0] stall_count;
`endif

    always #5 clk = ~clk;

    accum_stream_driver #(
        .MAX_LEN_BITS(MLB),
        .MIN_LEN     (MIN_LEN),
        .STOP_DELAY  (STOP_DELAY),
        .DATA_W      (DW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_config_valid    (cfg_v),
        .i_config_length   (cfg_len),
        .o_busy            (busy),
        .i_in_data         (in_data),
        .i_in_valid        (in_valid),
        .o_in_ready        (in_ready),
        .o_acc_in          (acc_in),
        .o_acc_start       (acc_start),
        .o_acc_stop        (acc_stop),
        .i_acc_out         (acc_out),
        .i_acc_output_valid(acc_ov),
        .o_result          (result),
        .o_result_valid    (result_valid)
`ifdef ACC_DRV_STATS_EN
        ,
        .o_stall_count     (stall_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          n;
        logic [15:0] re;
        logic [15:0] im;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    // Behavioural accumulator: sums everything from start through stop,
    // answers ACC_LAT cycles after stop, and throws spurious valid pulses
    // with garbage while a burst is running.
    logic [15:0] m_re, m_im;
    logic        m_run;
    int          m_dly;

    always @(posedge clk) begin
        if (reset) begin
            m_re   <= '0;
            m_im   <= '0;
            m_run  <= 1'b0;
            m_dly  <= 0;
            acc_ov <= 1'b0;
            acc_out <= '0;
        end else begin
            acc_ov  <= 1'b0;
            acc_out <= $urandom;
            if (acc_start) begin
                m_re  <= acc_in[31:16];
                m_im  <= acc_in[15:0];
                m_run <= 1'b1;
            end else if (m_run) begin
                m_re <= m_re + acc_in[31:16];
                m_im <= m_im + acc_in[15:0];
            end
            if (acc_stop && m_run) begin
                m_run <= 1'b0;
                m_dly <= ACC_LAT;
            end else if (m_dly > 0) begin
                m_dly <= m_dly - 1;
                if (m_dly == 1) begin
                    acc_ov  <= 1'b1;
                    acc_out <= {m_re, m_im};
                end
            end else if (m_run && ($urandom_range(0, 7) == 0)) begin
                acc_ov <= 1'b1;
            end
        end
    end

    // Monitor / scoreboard: observes framing and pops expectations on results.
    int  cyc;
    bit  act;
    bit  prev_rv;
    int  start_c, fires, last_f, stop_c, ov_c;
    bit  stop_seen;

    initial begin
        exp_t e;
        int   run_end;
        cyc = 0; act = 0; prev_rv = 0;
        start_c = 0; fires = 0; last_f = 0; stop_c = 0; ov_c = -100; stop_seen = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                act     = 0;
                prev_rv = 0;
            end else begin
                if (acc_start) begin
                    chk("start_in_burst", {63'd0, (!act && exp_q.size() > 0)}, 64'd1);
                    act = 1; start_c = cyc; fires = 0; last_f = cyc - 1;
                    stop_seen = 0; ov_c = -100;
                end
                if (act) chk("busy_in_burst", {63'd0, busy}, 64'd1);
                else     chk("ready_outside_burst", {63'd0, in_ready}, 64'd0);
                if (in_valid && in_ready) begin
                    fires++;
                    last_f = cyc;
                end
                if (acc_stop) begin
                    chk("stop_in_burst", {63'd0, (act && !stop_seen)}, 64'd1);
                    if (act && !stop_seen) begin
                        stop_seen = 1;
                        stop_c    = cyc;
                        run_end   = (last_f > start_c + MIN_LEN - 1) ? last_f : start_c + MIN_LEN - 1;
                        chk("stop_cycle", 64'(cyc - start_c), 64'(run_end + STOP_DELAY - start_c));
                    end
                end
                if (acc_ov && act && stop_seen && cyc > stop_c && ov_c < 0) ov_c = cyc;
                if (result_valid) begin
                    chk("rv_single_cycle", {63'd0, prev_rv}, 64'd0);
                    chk("rv_in_burst", {63'd0, (act && exp_q.size() > 0)}, 64'd1);
                    if (act && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("result", {32'd0, result}, {32'd0, e.re, e.im});
                        chk("accepted", 64'(fires), 64'(e.n));
                        chk("rv_latency", 64'(cyc - ov_c), 64'd2);
`ifdef ACC_DRV_STATS_EN
                        chk("stall_count", {51'd0, stall_count}, 64'(e.stalls));
`endif
                        act = 0;
                    end
                end
                prev_rv = result_valid;
            end
        end
    end

    // Stimulus: one burst. dmode 0:(k,0) 1:(k,k) 2:random; smode 0:always
    // valid 1:low every 3rd cycle 2:random stalls.
    task automatic burst(input int n, input int dmode, input int smode,
                         input int abort_at, input bit mid_cfg, input bit cfg_at_rv);
        logic [31:0] s[$];
        exp_t        e;
        logic [15:0] re, im, sr, si;
        int          idx, cnt, st, g;
        bit          v;
        sr = '0; si = '0;
        for (int k = 0; k < n; k++) begin
            case (dmode)
                0:       begin re = 16'(k + 1); im = 16'd0;      end
                1:       begin re = 16'(k + 1); im = 16'(k + 1); end
                default: begin re = 16'($urandom); im = 16'($urandom); end
            endcase
            s.push_back({re, im});
            sr = sr + re;
            si = si + im;
        end
        e.n = n; e.re = sr; e.im = si; e.stalls = 0;
        exp_q.push_back(e);

        cfg_v = 1'b1; cfg_len = MLB'(n);
        @(posedge clk); #1;
        cfg_v = 1'b0;

        idx = 0; cnt = 0; st = 0;
        while (idx < n && cnt < 4000 && !(abort_at >= 0 && idx == abort_at)) begin
            case (smode)
                0:       v = 1'b1;
                1:       v = ((cnt % 3) != 2);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = v;
            in_data  = v ? s[idx] : $urandom;
            if (!v) st++;
            else if (in_ready) idx++;
            if (mid_cfg && cnt == 4) begin cfg_v = 1'b1; cfg_len = MLB'(5); end
            else cfg_v = 1'b0;
            cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_data = $urandom; cfg_v = 1'b0;
        if (cnt >= 4000) chk("feed_timeout", 64'(idx), 64'(n));
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1].stalls = st;

        if (abort_at >= 0 && idx == abort_at) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("abort_busy", {63'd0, busy}, 64'd0);
            chk("abort_ready", {63'd0, in_ready}, 64'd0);
            void'(exp_q.pop_back());
            for (int k = 0; k < 30; k++) begin
                chk("abort_no_stop", {63'd0, acc_stop}, 64'd0);
                @(posedge clk); #1;
            end
            return;
        end

        g = 0;
        while (!result_valid && g < 600) begin
            @(posedge clk); #1;
            g++;
        end
        chk("result_timeout", {63'd0, result_valid}, 64'd1);
        if (cfg_at_rv) begin
            cfg_v = 1'b1; cfg_len = MLB'(7);
            @(posedge clk); #1;
            cfg_v = 1'b0;
            chk("cfg_at_rv_ignored", {63'd0, busy}, 64'd0);
        end else begin
            @(posedge clk); #1;
            chk("idle_after_result", {63'd0, busy}, 64'd0);
        end
        chk("result_hold", {32'd0, result}, {32'd0, sr, si});
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cfg_v = 1'b0; cfg_len = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   {63'd0, busy},         64'd0);
        chk("reset_ready",  {63'd0, in_ready},     64'd0);
        chk("reset_start",  {63'd0, acc_start},    64'd0);
        chk("reset_stop",   {63'd0, acc_stop},     64'd0);
        chk("reset_rv",     {63'd0, result_valid}, 64'd0);
        chk("reset_result", {32'd0, result},       64'd0);
        chk("reset_acc_in", {32'd0, acc_in},       64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        burst(16, 0, 0, -1, 1'b0, 1'b0);
        burst(16, 0, 1, -1, 1'b0, 1'b0);
        burst(3,  1, 0, -1, 1'b0, 1'b0);
        burst(0,  2, 0, -1, 1'b0, 1'b0);
        burst(20, 2, 0, -1, 1'b1, 1'b1);
        burst(20, 2, 0,  7, 1'b0, 1'b0);
        burst(12, 2, 0, -1, 1'b0, 1'b0);
        burst(12, 2, 2, -1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            burst(int'($urandom_range(0, 40)), 2, 2, -1, 1'b0, 1'b0);
        end
        burst(511, 2, 2, -1, 1'b0, 1'b0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/accum_stream_driver.md
Name: accum_stream_driver

Overview:
- Transmit-side framer for the complex accumulator.
- Accepts a length-configured burst of complex_t samples from an upstream valid/ready source and drives the accumulator's contiguous data and start/stop framing.
- Waits for the accumulator's output_valid and returns the captured sum as a one-cycle result.
- Sits between the per-channel sample buffer and each accumulator instance.

Parameters:
- MAX_LEN_BITS, 9: width of config_length; max burst 2^MAX_LEN_BITS-1.
- MIN_LEN, 12: minimum cycles the accumulator sees between start and end of data (must be >11).
- STOP_DELAY, 11: cycles from last data cycle to acc_stop pulse (covers adder feedback pipeline).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- config_valid  in  1  load new burst length (IDLE only)
- config_length  in  MAX_LEN_BITS  number of samples N in burst
- busy  out  1  high when state != IDLE
- in_data  in  complex_t  upstream sample
- in_valid  in  1  upstream sample valid
- in_ready  out  1  driver accepts sample this cycle
- acc_in  out  complex_t  to accumulator in
- acc_start  out  1  to accumulator start
- acc_stop  out  1  to accumulator stop
- acc_out  in  complex_t  from accumulator out
- acc_output_valid  in  1  from accumulator output_valid
- result  out  complex_t  captured sum
- result_valid  out  1  one-cycle pulse, result valid

Behaviour:
- Reset:
  - All outputs 0; result = '{0,0}; state IDLE.
  - Reset mid-burst aborts immediately; no acc_stop is emitted (accumulator shares reset).
- States: IDLE -> RUN -> FLUSH -> WAIT -> IDLE.
- IDLE:
  - in_ready=0, acc_in=0.
  - config_valid sampled high at edge T: latch N=config_length, clear counters, enter RUN at T+1.
  - config_valid while busy is ignored.
- RUN:
  - acc_start=1 in the first RUN cycle only.
  - in_ready=1 while accepted<N.
  - acc_in=in_data when in_valid&&in_ready, else '{0,0}. Stalls inject zeros, so the sum is unaffected and the accumulator always sees a contiguous stream.
  - Leave RUN after the cycle in which accepted==N and RUN cycle count >= MIN_LEN.
  - If N<MIN_LEN, pad with zeros until MIN_LEN cycles have elapsed.
  - N=0 gives MIN_LEN zero cycles; result is 0.
- FLUSH:
  - acc_in=0, in_ready=0 for STOP_DELAY cycles.
  - acc_stop=1 in the final FLUSH cycle only (STOP_DELAY cycles after the last RUN cycle); then WAIT.
- WAIT:
  - acc_in=0.
  - acc_output_valid sampled high at cycle V: register acc_out at V+1.
  - result_valid=1 and result updated in cycle V+2 for exactly one cycle, then IDLE.
  - acc_output_valid outside WAIT is ignored.
- Simultaneous events:
  - config_valid on the same cycle as the result_valid pulse is ignored (state not yet IDLE); accepted on the next cycle.
- result holds its value until the next capture.
- Counters are MAX_LEN_BITS+1 wide; no wrap within a burst.
- Arithmetic: no arithmetic on data; complex_t passes through unmodified (width per common.vh).

Optional Feature:
- ACC_DRV_STATS_EN defined:
  - Adds output stall_count [MAX_LEN_BITS+3:0]: counts RUN cycles with in_ready=1 and in_valid=0.
  - Clears on burst start; holds after the burst; reset to 0.
- Not defined: port absent, no counter logic.

Test Plan:
- N=16, in_valid always 1, samples k+j*0 for k=1..16:
  - acc_start in first RUN cycle; acc_stop 11 cycles after 16th sample.
  - result='{136,0}, result_valid one cycle.
- N=16, same data with in_valid low every 3rd cycle:
  - 16 samples accepted; zeros injected on stalls.
  - result='{136,0}; with ACC_DRV_STATS_EN, stall_count equals the number of low cycles.
- N=3, samples (1,1),(2,2),(3,3):
  - RUN lasts MIN_LEN=12 cycles with 9 zero pads.
  - result='{6,6}.
- N=0:
  - 12 zero cycles, acc_stop issued.
  - result='{0,0}; in_ready never high.
- config_valid pulsed while busy with length 5 during an N=20 burst:
  - ignored; exactly 20 samples consumed, busy stays high until result_valid.
- reset asserted in RUN after 7 samples:
  - next cycle busy=0, in_ready=0, acc_stop never pulses.
  - new N=12 burst completes with the correct sum.
